// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced push-button level into press/release
// pulses, a long-press pulse, auto-repeat pulses, a held level and a wrapping
// 8-bit press count. All outputs are registered.
// Optional feature: define DOUBLE_CLICK_EN to build the double-click window;
// without it o_dclick is constant 0 and no window logic exists.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int CNT_W         = 25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clean_in,
  output logic       o_press,
  output logic       o_rel_pulse,
  output logic       o_long_press,
  output logic       o_repeat_pulse,
  output logic       o_held,
  output logic [7:0] o_press_count,
  output logic       o_dclick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // Terminal counts: the counter restarts at 0 on the entry edge, so the event
  // edge is the one where the counter already shows CYCLES-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam longint           CNT_SPAN    = longint'(1) << CNT_W;

  // Reject configurations the hold/window counter cannot represent.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || DCLICK_CYCLES < 1 ||
      longint'(LONG_CYCLES) > CNT_SPAN || longint'(REPEAT_CYCLES) > CNT_SPAN ||
      longint'(DCLICK_CYCLES) > CNT_SPAN) begin : g_bad_cfg
    $error("button_event_decoder: invalid cycle parameters for CNT_W");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_prev;
  logic             w_rise;
  logic             w_press_nxt;
  logic             w_rel_nxt;
  logic             w_long_nxt;
  logic             w_rep_nxt;
  logic             w_held_nxt;
  logic             w_dclick_nxt;
  logic             r_press;
  logic             r_rel;
  logic             r_long;
  logic             r_rep;
  logic             r_held;
  logic             r_dclick;
  logic [7:0]       r_press_count;

  assign w_rise = i_clean_in & ~r_prev;

  // Next-state and next-pulse decode; a release always beats long/repeat events.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    w_rep_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HELD;
          w_press_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
        w_cnt_nxt = '0;
      end
      ST_HELD: begin
        if (!i_clean_in) begin
          w_state_nxt = ST_IDLE;
          w_rel_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!i_clean_in) begin
          w_state_nxt = ST_IDLE;
          w_rel_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == REPEAT_LAST) begin
          w_rep_nxt = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_held_nxt = (w_state_nxt != ST_IDLE);
  end

`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  logic             r_win_open;
  logic [CNT_W-1:0] r_win_cnt;
  logic             w_win_open_nxt;
  logic [CNT_W-1:0] w_win_cnt_nxt;

  // Double-click window: opened by a release, consumed by the next press, closed on expiry.
  always_comb begin
    w_dclick_nxt   = 1'b0;
    w_win_open_nxt = r_win_open;
    w_win_cnt_nxt  = r_win_cnt;
    if (w_rel_nxt) begin
      w_win_open_nxt = 1'b1;
      w_win_cnt_nxt  = '0;
    end else if (w_press_nxt) begin
      w_dclick_nxt   = r_win_open;
      w_win_open_nxt = 1'b0;
      w_win_cnt_nxt  = '0;
    end else if (r_win_open) begin
      if (r_win_cnt == DCLICK_LAST) begin
        w_win_open_nxt = 1'b0;
        w_win_cnt_nxt  = '0;
      end else begin
        w_win_cnt_nxt = r_win_cnt + CNT_W'(1);
      end
    end else begin
      w_win_cnt_nxt = '0;
    end
  end

  // Window registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_open <= 1'b0;
      r_win_cnt  <= '0;
    end else begin
      r_win_open <= w_win_open_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
    end
  end
`else
  assign w_dclick_nxt = 1'b0;
`endif

  // FSM state and hold counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= i_clean_in;
    end
  end

  // Registered outputs and the wrapping press counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press       <= 1'b0;
      r_rel         <= 1'b0;
      r_long        <= 1'b0;
      r_rep         <= 1'b0;
      r_held        <= 1'b0;
      r_dclick      <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_press  <= w_press_nxt;
      r_rel    <= w_rel_nxt;
      r_long   <= w_long_nxt;
      r_rep    <= w_rep_nxt;
      r_held   <= w_held_nxt;
      r_dclick <= w_dclick_nxt;
      if (w_press_nxt) begin
        r_press_count <= r_press_count + 8'd1;
      end else begin
        r_press_count <= r_press_count;
      end
    end
  end

  assign o_press        = r_press;
  assign o_rel_pulse    = r_rel;
  assign o_long_press   = r_long;
  assign o_repeat_pulse = r_rep;
  assign o_held         = r_held;
  assign o_dclick       = r_dclick;
  assign o_press_count  = r_press_count;

endmodule
